// File: rtl/memory_management_unit_pkg.sv
// Shared types and constants for the memory management unit.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package memory_management_unit_pkg;

    localparam int DEFAULT_WIDTH = 256;
    localparam int DEFAULT_XLEN  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } mmu_state_t;

    typedef enum logic {
        PORT_ICACHE = 1'b0,
        PORT_DCACHE = 1'b1
    } port_sel_t;

    // Round-robin pick: a lone requester always wins; on a tie the port that
    // was not served last wins.
    function automatic port_sel_t rr_pick(input logic icache_req,
                                          input logic dcache_req,
                                          input port_sel_t last);
        if (icache_req && dcache_req)
            return (last == PORT_ICACHE) ? PORT_DCACHE : PORT_ICACHE;
        else if (dcache_req)
            return PORT_DCACHE;
        else
            return PORT_ICACHE;
    endfunction

endpackage

// File: rtl/memory_management_unit_arbiter.sv
// Round-robin arbiter between the instruction and data cache ports.
// Latency: grant is combinational; last-grant register updates on the update pulse.
// Backpressure: none of its own; losers simply stay pending in the requesters.
//
// Ports: clk, reset (async, active-high); icache_req, dcache_req (pending
// requests); update/served_dcache (record which port was just served);
// grant_dcache (1 = data cache wins, 0 = instruction cache wins).
module mmu_arbiter
    import memory_management_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic icache_req,
    input  logic dcache_req,
    input  logic update,
    input  logic served_dcache,
    output logic grant_dcache
);

    port_sel_t last_grant;

    // Reset to icache so the data cache wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= PORT_ICACHE;
        else if (update)
            last_grant <= port_sel_t'(served_dcache);
    end

    assign grant_dcache = (rr_pick(icache_req, dcache_req, last_grant) == PORT_DCACHE);

endmodule

// File: rtl/memory_management_unit.sv
// Arbitrates icache/dcache line requests onto a single main-memory port.
// Latency: 3 cycles request-to-done minimum (IDLE -> ISSUE -> WAIT -> RESPOND).
// Backpressure: ready only in IDLE; ISSUE stalls on mem_ready, WAIT stalls until mem_done.
//
// Ports: clk, reset; icache_address/read -> icache_rdata/ready/done;
// dcache_address/read/write/wdata -> dcache_rdata/ready/done;
// mem_address/read/write/wdata -> memory, mem_rdata/ready/done <- memory.
module memory_management_unit
    import memory_management_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int XLEN  = DEFAULT_XLEN
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  icache_address,
    input  logic             icache_read,
    output logic [WIDTH-1:0] icache_rdata,
    output logic             icache_ready,
    output logic             icache_done,
    input  logic [XLEN-1:0]  dcache_address,
    input  logic             dcache_read,
    input  logic             dcache_write,
    input  logic [WIDTH-1:0] dcache_wdata,
    output logic [WIDTH-1:0] dcache_rdata,
    output logic             dcache_ready,
    output logic             dcache_done,
    output logic [XLEN-1:0]  mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    input  logic             mem_done
);

    mmu_state_t       state;
    port_sel_t        owner;
    logic [XLEN-1:0]  addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             op_write_q;

    logic dcache_req;
    logic any_req;
    logic grant_dcache;
    logic mem_active;

    assign dcache_req = dcache_read | dcache_write;
    assign any_req    = icache_read | dcache_req;

    mmu_arbiter u_arbiter (
        .clk           (clk),
        .reset         (reset),
        .icache_req    (icache_read),
        .dcache_req    (dcache_req),
        .update        (state == ST_RESPOND),
        .served_dcache (owner == PORT_DCACHE),
        .grant_dcache  (grant_dcache)
    );

    assign icache_ready = (state == ST_IDLE);
    assign dcache_ready = (state == ST_IDLE);

    // The request strobe is gated by mem_ready while issuing, then held
    // through WAIT until memory reports completion.
    assign mem_active  = ((state == ST_ISSUE) && mem_ready) || (state == ST_WAIT);
    assign mem_read    = mem_active && !op_write_q;
    assign mem_write   = mem_active &&  op_write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            owner        <= PORT_ICACHE;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_write_q   <= 1'b0;
            icache_rdata <= '0;
            dcache_rdata <= '0;
            icache_done  <= 1'b0;
            dcache_done  <= 1'b0;
        end else begin
            icache_done <= 1'b0;
            dcache_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state <= ST_ISSUE;
                        if (grant_dcache) begin
                            owner      <= PORT_DCACHE;
                            addr_q     <= dcache_address;
                            // Write takes precedence when both strobes are high.
                            op_write_q <= dcache_write;
                            wdata_q    <= dcache_write ? dcache_wdata : '0;
                        end else begin
                            owner      <= PORT_ICACHE;
                            addr_q     <= icache_address;
                            op_write_q <= 1'b0;
                            wdata_q    <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        state <= ST_RESPOND;
                        // Done is registered here so it is high exactly in RESPOND.
                        if (owner == PORT_DCACHE) begin
                            dcache_done <= 1'b1;
                            if (!op_write_q)
                                dcache_rdata <= mem_rdata;
                        end else begin
                            icache_done <= 1'b1;
                            if (!op_write_q)
                                icache_rdata <= mem_rdata;
                        end
                    end
                end
                ST_RESPOND: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_management_unit.sv
module tb_memory_management_unit;

    localparam int WIDTH = 256;
    localparam int XLEN  = 32;

    logic             clk;
    logic             reset;
    logic [XLEN-1:0]  icache_address;
    logic             icache_read;
    logic [WIDTH-1:0] icache_rdata;
    logic             icache_ready;
    logic             icache_done;
    logic [XLEN-1:0]  dcache_address;
    logic             dcache_read;
    logic             dcache_write;
    logic [WIDTH-1:0] dcache_wdata;
    logic [WIDTH-1:0] dcache_rdata;
    logic             dcache_ready;
    logic             dcache_done;
    logic [XLEN-1:0]  mem_address;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;
    logic             mem_done;

    memory_management_unit #(.WIDTH(WIDTH), .XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_address (icache_address),
        .icache_read    (icache_read),
        .icache_rdata   (icache_rdata),
        .icache_ready   (icache_ready),
        .icache_done    (icache_done),
        .dcache_address (dcache_address),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_ready   (dcache_ready),
        .dcache_done    (dcache_done),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .mem_done       (mem_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } mem_exp_t;

    typedef struct {
        logic         port;   // 0 = icache, 1 = dcache
        logic [255:0] rdata;
    } resp_exp_t;

    mem_exp_t  exp_mem_q[$];
    resp_exp_t exp_resp_q[$];

    int tests = 0;
    int fails = 0;
    int done_count = 0;
    int stray_req = 0;
    logic suppress_done = 1'b0;
    logic [255:0] mi = '0;   // model of icache_rdata
    logic [255:0] md = '0;   // model of dcache_rdata

    localparam logic [255:0] JUNK = {8{32'hBAD0_BAD0}};

    function automatic logic [255:0] pat(input logic [31:0] a);
        return {8{32'h5EED_0000 ^ a}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input logic port, input logic [31:0] addr, input logic wr,
                              input logic [255:0] wdata, input logic [255:0] rdata);
        mem_exp_t  m;
        resp_exp_t r;
        m.addr = addr; m.wr = wr; m.wdata = wdata; m.rdata = rdata;
        if (!wr) begin
            if (port) md = rdata; else mi = rdata;
        end
        r.port  = port;
        r.rdata = port ? md : mi;
        exp_mem_q.push_back(m);
        exp_resp_q.push_back(r);
    endtask

    task automatic run_icache(input logic [31:0] addr, input logic drop_early, output int lat);
        icache_address = addr;
        icache_read    = 1'b1;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (drop_early) icache_read = 1'b0;
            if (icache_done) begin
                lat = n;
                break;
            end
        end
        icache_read = 1'b0;
        if (lat == 0) begin
            tests++; fails++;
            $display("FAIL icache_timeout: no done for addr %h within 100 cycles", addr);
        end
    endtask

    task automatic run_dcache(input logic [31:0] addr, input logic rd, input logic wr,
                              input logic [255:0] wd, output int lat);
        dcache_address = addr;
        dcache_read    = rd;
        dcache_write   = wr;
        dcache_wdata   = wd;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (dcache_done) begin
                lat = n;
                break;
            end
        end
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        if (lat == 0) begin
            tests++; fails++;
            $display("FAIL dcache_timeout: no done for addr %h within 100 cycles", addr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        mi = '0; md = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Memory model: sole driver of mem_done / mem_rdata.
    initial begin
        int stray_seen;
        mem_exp_t e;
        stray_seen = 0;
        mem_done   = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                mem_rdata  = JUNK;
                mem_done   = 1'b1;
                @(negedge clk);
                mem_done   = 1'b0;
            end else if (!reset && mem_ready && (mem_read || mem_write)) begin
                if (exp_mem_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mem_unexpected: issue to %h rd=%0d wr=%0d", mem_address, mem_read, mem_write);
                    e.rdata = JUNK;
                end else begin
                    e = exp_mem_q.pop_front();
                    check("mem_address", 256'(mem_address), 256'(e.addr));
                    check("mem_write", 256'(mem_write), 256'(e.wr));
                    check("mem_read", 256'(mem_read), 256'(!e.wr));
                    if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
                end
                if (!suppress_done) begin
                    @(negedge clk);
                    mem_rdata = e.rdata;
                    mem_done  = 1'b1;
                    @(negedge clk);
                    mem_done  = 1'b0;
                end else begin
                    for (int k = 0; k < 50 && (mem_read || mem_write); k++) @(negedge clk);
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_exp_t r;
        forever begin
            @(negedge clk);
            if (!reset && (icache_done || dcache_done)) begin
                done_count++;
                check("done_onehot", 256'(icache_done & dcache_done), 256'(0));
                if (exp_resp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL resp_unexpected: icache_done=%0d dcache_done=%0d", icache_done, dcache_done);
                end else begin
                    r = exp_resp_q.pop_front();
                    check("resp_port", 256'(dcache_done), 256'(r.port));
                    check("resp_rdata", r.port ? dcache_rdata : icache_rdata, r.rdata);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_i, lat_d, saved;
        reset = 1'b1;
        icache_address = '0; icache_read = 1'b0;
        dcache_address = '0; dcache_read = 1'b0; dcache_write = 1'b0; dcache_wdata = '0;
        mem_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_icache_ready", 256'(icache_ready), 256'(1));
        check("rst_dcache_ready", 256'(dcache_ready), 256'(1));
        check("rst_dones", 256'({icache_done, dcache_done}), 256'(0));
        check("rst_mem_rw", 256'({mem_read, mem_write}), 256'(0));
        check("rst_mem_address", 256'(mem_address), 256'(0));
        check("rst_mem_wdata", mem_wdata, 256'(0));
        check("rst_rdata", icache_rdata | dcache_rdata, 256'(0));
        reset = 1'b0;

        // icache read right after reset: done in cycle 3
        expect_txn(1'b0, 32'h0000_1000, 1'b0, '0, {8{32'hDEADBEEF}});
        run_icache(32'h0000_1000, 1'b0, lat_i);
        check("lat_icache_min", 256'(lat_i), 256'(3));

        // Simultaneous requests after reset: dcache wins the first tie
        do_reset();
        expect_txn(1'b1, 32'h200, 1'b1, {8{32'hFACE_0200}}, JUNK);
        expect_txn(1'b0, 32'h100, 1'b0, '0, pat(32'h100));
        fork
            run_icache(32'h100, 1'b0, lat_i);
            run_dcache(32'h200, 1'b0, 1'b1, {8{32'hFACE_0200}}, lat_d);
        join
        check("tie_lat_dcache", 256'(lat_d), 256'(3));
        check("tie_lat_icache", 256'(lat_i), 256'(7));

        // mem_ready low for 5 ISSUE cycles
        @(negedge clk);
        mem_ready = 1'b0;
        expect_txn(1'b1, 32'h300, 1'b0, '0, pat(32'h300));
        fork
            run_dcache(32'h300, 1'b1, 1'b0, '0, lat_d);
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("stall_no_req", 256'({mem_read, mem_write}), 256'(0));
                    check("stall_addr", 256'(mem_address), 256'(32'h300));
                end
                @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        join
        check("stall_lat", 256'(lat_d), 256'(8));

        // read+write together is a write; dcache_rdata must stay unchanged
        @(negedge clk);
        expect_txn(1'b1, 32'h40, 1'b1, {8{32'h1234_0040}}, JUNK);
        run_dcache(32'h40, 1'b1, 1'b1, {8{32'h1234_0040}}, lat_d);

        // requester drops early: transaction still completes
        @(negedge clk);
        expect_txn(1'b0, 32'h500, 1'b0, '0, pat(32'h500));
        run_icache(32'h500, 1'b1, lat_i);
        check("drop_lat", 256'(lat_i), 256'(3));

        // Reset while in WAIT, then a late mem_done
        do_reset();
        suppress_done = 1'b1;
        begin
            mem_exp_t m;
            m.addr = 32'h80; m.wr = 1'b0; m.wdata = '0; m.rdata = '0;
            exp_mem_q.push_back(m);
        end
        dcache_address = 32'h80;
        dcache_read    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("wait_mem_read", 256'(mem_read), 256'(1));
        saved = done_count;
        reset = 1'b1;
        dcache_read = 1'b0;
        mi = '0; md = '0;
        #1;
        check("async_rst_ready", 256'({icache_ready, dcache_ready}), 256'(2'b11));
        check("async_rst_mem_read", 256'(mem_read), 256'(0));
        check("async_rst_addr", 256'(mem_address), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        suppress_done = 1'b0;
        @(negedge clk);
        stray_req++;
        repeat (4) @(negedge clk);
        check("late_done_no_pulse", 256'(done_count), 256'(saved));
        check("late_done_ready", 256'({icache_ready, dcache_ready}), 256'(2'b11));
        check("late_done_mem_idle", 256'({mem_read, mem_write}), 256'(0));

        // 20 back-to-back transactions: strict alternation starting with dcache
        do_reset();
        for (int i = 0; i < 10; i++) begin
            expect_txn(1'b1, 32'h4000 + 32'(i) * 32'h40, 1'b0, '0, pat(32'h4000 + 32'(i) * 32'h40));
            expect_txn(1'b0, 32'h3000 + 32'(i) * 32'h40, 1'b0, '0, pat(32'h3000 + 32'(i) * 32'h40));
        end
        fork
            begin
                int ld;
                for (int i = 0; i < 10; i++)
                    run_dcache(32'h4000 + 32'(i) * 32'h40, 1'b1, 1'b0, '0, ld);
            end
            begin
                int li;
                for (int j = 0; j < 10; j++)
                    run_icache(32'h3000 + 32'(j) * 32'h40, 1'b0, li);
            end
        join

        repeat (5) @(negedge clk);
        check("resp_queue_empty", 256'(exp_resp_q.size()), 256'(0));
        check("mem_queue_empty", 256'(exp_mem_q.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
